// File: rtl/crc_pkg.sv
// Shared CRC-32 constants: width, generator polynomial and LFSR seed, reused by
// the CRC engine and by frame packers/checkers.
package crc_pkg;

    localparam int unsigned  CRC_W    = 32;
    localparam logic [31:0]  CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0]  CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_if.sv
// Dibit stream into the CRC engine and running CRC back out.
interface crc32_if;
    import crc_pkg::*;

    logic             axiiv;
    logic [1:0]       axiid;
    logic             axiov;
    logic [CRC_W-1:0] axiod;

    modport master (output axiiv, output axiid, input axiov, input axiod);
    modport slave  (input axiiv, input axiid, output axiov, output axiod);

endinterface

// File: rtl/crc32.sv
// Dibit-serial CRC-32 engine: two LFSR steps per accepted dibit, running CRC
// presented as the complement of the state one cycle after each dibit.
module crc32
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY,
    parameter logic [CRC_W-1:0] INIT = CRC_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [1:0]       axiid,
    output logic             axiov,
    output logic [CRC_W-1:0] axiod
);

    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic             valid_q, valid_d;

    function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] s,
                                                   input logic             b);
        logic fb;
        fb = s[CRC_W-1] ^ b;
        return (s << 1) ^ (fb ? POLY : '0);
    endfunction

    // axiid[1] is the earlier bit, so it goes through the LFSR first.
    always_comb begin
        lfsr_d  = lfsr_q;
        valid_d = axiiv;
        if (axiiv) begin
            lfsr_d = lfsr_step(lfsr_step(lfsr_q, axiid[1]), axiid[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= INIT;
            valid_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
        end
    end

    assign axiov = valid_q;
    assign axiod = ~lfsr_q;

endmodule

// File: tb/tb_crc32.sv
// Self-checking bench for crc32: fixed vectors, "123456789" sequences and
// random streams against a polynomial long-division reference.
module tb_crc32;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    crc32_if bus();

    crc32 #(.POLY(CRC_POLY), .INIT(CRC_INIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (bus.axiiv),
        .axiid (bus.axiid),
        .axiov (bus.axiov),
        .axiod (bus.axiod)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  d;
        logic [31:0] exp;
    } vec_t;

    bit          msg[$];
    logic [31:0] prev_crc;
    int          pulses;

    // CRC as remainder of (M(x)*x^32 + INIT*x^len) mod P, complemented.
    function automatic logic [31:0] ref_crc(input bit m[$]);
        bit          dv[$];
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] rem;
        int unsigned len;
        poly = CRC_POLY;
        init = CRC_INIT;
        len  = m.size();
        dv   = m;
        for (int i = 0; i < 32; i++) dv.push_back(1'b0);
        for (int i = 0; i < 32; i++) dv[i] = dv[i] ^ init[31-i];
        for (int unsigned i = 0; i < len; i++) begin
            if (dv[i]) begin
                dv[i] = 1'b0;
                for (int j = 1; j <= 32; j++) dv[i+j] = dv[i+j] ^ poly[32-j];
            end
        end
        rem = '0;
        for (int k = 0; k < 32; k++) rem[31-k] = dv[len+k];
        return ~rem;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.axiiv = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        msg.delete();
        check("reset_axiov", {31'd0, bus.axiov}, 32'd0);
        check("reset_axiod", bus.axiod, 32'h00000000);
        prev_crc = bus.axiod;
    endtask

    task automatic send(input string name, input logic [1:0] d);
        bus.axiid = d;
        bus.axiiv = 1'b1;
        @(posedge clk); #1;
        bus.axiiv = 1'b0;
        msg.push_back(d[1]);
        msg.push_back(d[0]);
        if (bus.axiov === 1'b1) pulses++;
        check({name, "_axiov"}, {31'd0, bus.axiov}, 32'd1);
        check({name, "_axiod"}, bus.axiod, ref_crc(msg));
        prev_crc = bus.axiod;
    endtask

    task automatic idle(input string name);
        bus.axiiv = 1'b0;
        bus.axiid = 2'($urandom);
        @(posedge clk); #1;
        if (bus.axiov === 1'b1) pulses++;
        check({name, "_axiov"}, {31'd0, bus.axiov}, 32'd0);
        check({name, "_hold"}, bus.axiod, prev_crc);
    endtask

    task automatic send_check_str(input string name, input int gaps);
        logic [7:0] b;
        for (int i = 0; i < 9; i++) begin
            b = 8'h31 + 8'(i);
            for (int k = 3; k >= 0; k--) begin
                send(name, b[2*k +: 2]);
                if (gaps != 0) repeat ($urandom_range(0, 3)) idle(name);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[4];
        bit   one[$];

        tbl[0] = '{"dibit00", 2'b00, 32'h0D4326DA};
        tbl[1] = '{"dibit11", 2'b11, 32'h00000003};
        one = '{1'b0, 1'b1};
        tbl[2] = '{"dibit01", 2'b01, ref_crc(one)};
        one = '{1'b1, 1'b0};
        tbl[3] = '{"dibit10", 2'b10, ref_crc(one)};

        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        pulses    = 0;
        @(posedge clk); #1;

        // Idle after reset holds zero indefinitely.
        do_reset();
        repeat (6) idle("idle");

        // Single dibits after reset, then one idle cycle.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            bus.axiid = tbl[i].d;
            bus.axiiv = 1'b1;
            @(posedge clk); #1;
            bus.axiiv = 1'b0;
            check({tbl[i].name, "_axiov"}, {31'd0, bus.axiov}, 32'd1);
            check({tbl[i].name, "_axiod"}, bus.axiod, tbl[i].exp);
            prev_crc = bus.axiod;
            idle({tbl[i].name, "_after"});
        end

        // "123456789" back to back.
        do_reset();
        pulses = 0;
        send_check_str("str", 0);
        check("str_final", bus.axiod, 32'hFC891918);
        check("str_pulses", pulses, 36);
        idle("str_after");

        // Same stream with random gaps.
        do_reset();
        pulses = 0;
        send_check_str("gap", 1);
        check("gap_final", bus.axiod, 32'hFC891918);
        check("gap_pulses", pulses, 36);

        // Reset mid-stream; the dibit alongside rst is dropped.
        do_reset();
        for (int i = 0; i < 18; i++) send("half", 2'($urandom));
        bus.axiid = 2'b10;
        bus.axiiv = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.axiiv = 1'b0;
        msg.delete();
        check("midrst_axiov", {31'd0, bus.axiov}, 32'd0);
        check("midrst_axiod", bus.axiod, 32'h00000000);
        prev_crc = bus.axiod;
        send_check_str("restart", 0);
        check("restart_final", bus.axiod, 32'hFC891918);

        // Random streams against the reference.
        for (int t = 0; t < 20; t++) begin
            do_reset();
            repeat ($urandom_range(1, 40)) begin
                send("rand", 2'($urandom));
                if ($urandom_range(0, 2) == 0) idle("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
